bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, fixed-priority, non-preemptive system-bus arbiter.
- Samples the request lines and target-slave selects of master 1 and master 2, and grants the bus to one master at a time.
- Drives a bus-grant code and a registered slave select to the bus mux/decoder.
- Sits between the two master interfaces and the shared address/data mux of the system bus.

Parameters:
- SLAVE_SEL_W, 2, width of each slave-select field (up to 4 slaves).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- m1_request  input  1  master 1 requests the bus (level, held for the whole transfer).
- m2_request  input  1  master 2 requests the bus (level, held for the whole transfer).
- m1_slave_sel  input  SLAVE_SEL_W  target slave of master 1.
- m2_slave_sel  input  SLAVE_SEL_W  target slave of master 2.
- m1_grant  output  1  bus owned by master 1.
- m2_grant  output  1  bus owned by master 2.
- arbiter_busy  output  1  bus currently owned by some master.
- bus_grant  output  2  owner code: 00 none, 01 master 1, 10 master 2; 11 never driven.
- slave_sel  output  SLAVE_SEL_W  slave selected by the current owner.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- All outputs are registered; none is combinational from the inputs.
- Reset values: state IDLE; m1_grant=0, m2_grant=0, arbiter_busy=0, bus_grant=00, slave_sel=0.
- Reset takes effect immediately, including mid-ownership. The grant is dropped with no completion cycle.
- FSM states: IDLE, M1_OWN, M2_OWN, one-hot or binary at implementer's choice.
- Transitions are evaluated at each rising edge on the sampled inputs:
  - IDLE: m1_request=1 -> M1_OWN (master 1 wins ties). Else m2_request=1 -> M2_OWN. Else stay IDLE.
  - M1_OWN: m1_request=1 -> stay (non-preemptive; m2_request is ignored). m1_request=0 and m2_request=1 -> M2_OWN directly, with no idle cycle. Both 0 -> IDLE.
  - M2_OWN: m2_request=1 -> stay (no preemption by master 1). m2_request=0 and m1_request=1 -> M1_OWN. Both 0 -> IDLE.
- Latency: the grant appears on the first rising edge at which the request is sampled high and the bus is free. It drops on the first edge at which the owner's request is sampled low.
- Output decode, registered with the state:
  - M1_OWN: m1_grant=1, bus_grant=01.
  - M2_OWN: m2_grant=1, bus_grant=10.
  - IDLE: bus_grant=00.
  - arbiter_busy = m1_grant | m2_grant.
- m1_grant and m2_grant are never both 1.
- slave_sel:
  - Loaded from the winning master's slave_sel on the edge the grant is issued, including a direct handover.
  - Held constant for the rest of that ownership; changes on the owner's select mid-transfer are ignored.
  - Returns to 0 when entering IDLE.
- No request is queued or remembered. A master that drops its request before being granted loses it.

Decomposition:
- Shared bus package holds:
  - SLAVE_SEL_W default.
  - bus_grant codes GNT_NONE=2'b00, GNT_M1=2'b01, GNT_M2=2'b10.
  - Arbiter state typedef/localparams.
- Single module, no sub-modules. The FSM and output registers are small enough to stay in bus_arbiter.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs go to 0 / 00 without waiting for a clock edge; they stay there while rst=1.
- Single master 1: m1_request=1, m1_slave_sel=10, m2_request=0 -> next edge m1_grant=1, bus_grant=01, slave_sel=10, arbiter_busy=1.
- Contention while owned: master 1 owns the bus, then m1_request=1, m2_request=1, m1_slave_sel=01, m2_slave_sel=10:
  - m1_grant stays 1 and m2_grant stays 0.
  - slave_sel stays 10, because it was latched at grant and is not updated to 01.
- Handover: m1_request=0, m2_request=1, m2_slave_sel=11 -> next edge m2_grant=1, m1_grant=0, bus_grant=10, slave_sel=11, with no IDLE cycle between owners.
- Simultaneous from IDLE: m1_request=1 and m2_request=1 on the same edge -> master 1 is granted (bus_grant=01). Then drop m1_request -> master 2 is granted on the next edge.
- Release and reset mid-ownership:
  - Owner drops its request with the other master idle -> next edge bus_grant=00, arbiter_busy=0, slave_sel=0.
  - Assert rst while M2_OWN -> m2_grant=0 immediately.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg : shared bus constants, grant codes and arbiter state type
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_arbiter_pkg;

  localparam int SLAVE_SEL_W = 2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M1   = 2'b01;
  localparam logic [1:0] GNT_M2   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_M1_OWN = 2'd1,
    ST_M2_OWN = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter : two-master fixed-priority non-preemptive bus arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int SLAVE_SEL_W = bus_arbiter_pkg::SLAVE_SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m1_request,
  input  logic                   m2_request,
  input  logic [SLAVE_SEL_W-1:0] m1_slave_sel,
  input  logic [SLAVE_SEL_W-1:0] m2_slave_sel,
  output logic                   m1_grant,
  output logic                   m2_grant,
  output logic                   arbiter_busy,
  output logic [1:0]             bus_grant,
  output logic [SLAVE_SEL_W-1:0] slave_sel
);

  arb_state_t state;
  arb_state_t next_state;

  // The owner keeps the bus while its request is held; on release the
  // other master takes over directly if it is waiting.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (m1_request)      next_state = ST_M1_OWN;
        else if (m2_request) next_state = ST_M2_OWN;
        else                 next_state = ST_IDLE;
      end
      ST_M1_OWN: begin
        if (!m1_request) next_state = m2_request ? ST_M2_OWN : ST_IDLE;
      end
      ST_M2_OWN: begin
        if (!m2_request) next_state = m1_request ? ST_M1_OWN : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      m1_grant     <= 1'b0;
      m2_grant     <= 1'b0;
      arbiter_busy <= 1'b0;
      bus_grant    <= GNT_NONE;
      slave_sel    <= '0;
    end else begin
      state        <= next_state;
      m1_grant     <= (next_state == ST_M1_OWN);
      m2_grant     <= (next_state == ST_M2_OWN);
      arbiter_busy <= (next_state != ST_IDLE);
      bus_grant    <= (next_state == ST_M1_OWN) ? GNT_M1 :
                      (next_state == ST_M2_OWN) ? GNT_M2 : GNT_NONE;
      // Select is captured only when ownership changes hands.
      if (next_state == ST_M1_OWN && state != ST_M1_OWN)
        slave_sel <= m1_slave_sel;
      else if (next_state == ST_M2_OWN && state != ST_M2_OWN)
        slave_sel <= m2_slave_sel;
      else if (next_state == ST_IDLE)
        slave_sel <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter : vector table, corner sequences and random model check
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         m1_request, m2_request;
  logic [W-1:0] m1_slave_sel, m2_slave_sel;
  logic         m1_grant, m2_grant, arbiter_busy;
  logic [1:0]   bus_grant;
  logic [W-1:0] slave_sel;

  int checks = 0;
  int errors = 0;

  // reference model: current owner (0 none, 1, 2) and latched select
  int           owner;
  logic [W-1:0] msel;

  bus_arbiter #(.SLAVE_SEL_W(W)) dut (
    .clk(clk), .rst(rst),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .arbiter_busy(arbiter_busy), .bus_grant(bus_grant),
    .slave_sel(slave_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         m1r, m2r;
    logic [W-1:0] m1s, m2s;
    logic [1:0]   eg;
    logic [W-1:0] es;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] eg, input logic [W-1:0] es);
    chk({tag, ".m1_grant"},     8'(m1_grant),     8'(eg == GNT_M1));
    chk({tag, ".m2_grant"},     8'(m2_grant),     8'(eg == GNT_M2));
    chk({tag, ".arbiter_busy"}, 8'(arbiter_busy), 8'(eg != GNT_NONE));
    chk({tag, ".bus_grant"},    8'(bus_grant),    8'(eg));
    chk({tag, ".slave_sel"},    8'(slave_sel),    8'(es));
  endtask

  function automatic logic [1:0] model_code();
    return (owner == 1) ? GNT_M1 : (owner == 2) ? GNT_M2 : GNT_NONE;
  endfunction

  // owner keeps bus while requesting; otherwise master 1 beats master 2
  task automatic model_step();
    int nxt;
    if (owner == 1 && m1_request)      nxt = 1;
    else if (owner == 2 && m2_request) nxt = 2;
    else if (m1_request)               nxt = 1;
    else if (m2_request)               nxt = 2;
    else                               nxt = 0;
    if (nxt != owner)
      msel = (nxt == 1) ? m1_slave_sel : (nxt == 2) ? m2_slave_sel : '0;
    owner = nxt;
  endtask

  task automatic drive(input logic r1, input logic r2, input logic [W-1:0] s1, input logic [W-1:0] s2);
    m1_request   = r1;
    m2_request   = r2;
    m1_slave_sel = s1;
    m2_slave_sel = s2;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 2'b00, 2'b00, GNT_NONE, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 2'b00, GNT_M1,   2'b10};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 2'b10, GNT_M1,   2'b10};
    vecs[3]  = '{1'b1, 1'b1, 2'b11, 2'b01, GNT_M1,   2'b10};
    vecs[4]  = '{1'b0, 1'b1, 2'b01, 2'b11, GNT_M2,   2'b11};
    vecs[5]  = '{1'b1, 1'b1, 2'b01, 2'b00, GNT_M2,   2'b11};
    vecs[6]  = '{1'b0, 1'b0, 2'b10, 2'b10, GNT_NONE, 2'b00};
    vecs[7]  = '{1'b1, 1'b1, 2'b01, 2'b10, GNT_M1,   2'b01};
    vecs[8]  = '{1'b0, 1'b1, 2'b11, 2'b10, GNT_M2,   2'b10};
    vecs[9]  = '{1'b1, 1'b0, 2'b11, 2'b00, GNT_M1,   2'b11};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 2'b01, GNT_NONE, 2'b00};
    vecs[11] = '{1'b0, 1'b1, 2'b10, 2'b01, GNT_M2,   2'b01};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 2'b11, GNT_NONE, 2'b00};

    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #2 rst = 1'b1;
    #1 check_all("reset_async", GNT_NONE, '0);
    drive(1'b1, 1'b1, 2'b11, 2'b11);
    repeat (2) @(posedge clk);
    #1 check_all("reset_held", GNT_NONE, '0);
    drive(1'b0, 1'b0, '0, '0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].m1r, vecs[i].m2r, vecs[i].m1s, vecs[i].m2s);
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), vecs[i].eg, vecs[i].es);
    end

    // reset while master 2 owns the bus
    drive(1'b0, 1'b1, 2'b00, 2'b01);
    @(posedge clk);
    #1 check_all("m2_own", GNT_M2, 2'b01);
    #2 rst = 1'b1;
    #1 check_all("reset_mid_m2", GNT_NONE, '0);
    @(posedge clk);
    #1 check_all("reset_mid_m2_held", GNT_NONE, '0);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    owner = 0;
    msel  = '0;
    @(posedge clk);
    #1 check_all("post_reset_idle", GNT_NONE, '0);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) == 0) ? ~m1_request : m1_request,
            ($urandom_range(0, 3) == 0) ? ~m2_request : m2_request,
            W'($urandom), W'($urandom));
      model_step();
      @(posedge clk);
      #1 check_all("random", model_code(), msel);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b1;
        #1 check_all("random_reset", GNT_NONE, '0);
        rst   = 1'b0;
        owner = 0;
        msel  = '0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
